serial_operand_tx: RTL
======================

Name: serial_operand_tx

Overview:
Transmit side of the serial compare interface. It loads two WIDTH-bit operands on a start request and streams them out one bit pair per transfer, MSB-first or LSB-first. A valid/ready handshake carries each bit pair, and a last flag marks the final pair. The serial comparator consumes this stream, and the done pulse marks the end of the operation for the control logic.

Parameters:
WIDTH, 32, operand width in bits and number of bit-pair transfers per operation; must be 2 or more.
CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
start  input  1  request to load a, b and mode; sampled only in IDLE.
mode  input  1  bit order, latched at start: 0 = MSB-first, 1 = LSB-first.
a  input  WIDTH  operand A, latched at start.
b  input  WIDTH  operand B, latched at start.
bit_ready  input  1  downstream can accept the current bit pair.
bit_valid  output  1  aout/bout/last hold a valid bit pair.
aout  output  1  current bit of operand A.
bout  output  1  current bit of operand B.
last  output  1  current pair is the final one (index WIDTH-1).
busy  output  1  an operation is in progress (SHIFT state).
done  output  1  one-cycle pulse after the last pair transfers.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; shift registers and counter cleared.
  - bit_valid=0, aout=0, bout=0, last=0, busy=0, done=0.
  - These values hold for as long as rst=0.
- Transfer rule: a transfer occurs on a rising edge where bit_valid=1 and bit_ready=1.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - With start=1 at an edge: latch a, b, mode into internal shift registers; counter=0; next state SHIFT.
  - With start=0: remain in IDLE.
- SHIFT:
  - busy=1 and bit_valid=1 throughout.
  - The first pair appears in the cycle after the start edge: a[WIDTH-1]/b[WIDTH-1] when mode=0, a[0]/b[0] when mode=1.
  - Each transfer shifts both registers one position toward the output end and increments the counter.
  - last=1 exactly when counter==WIDTH-1.
  - Transfer with last=1: next state DONE.
- DONE:
  - Lasts one cycle: done=1, busy=0, bit_valid=0, last=0; then IDLE unconditionally.
- Backpressure: while bit_valid=1 and bit_ready=0, aout, bout, last and the counter hold stable. bit_valid never drops mid-operation.
- Latency with bit_ready held at 1:
  - start edge at cycle 0; first pair valid in cycle 1.
  - Last transfer at the end of cycle WIDTH; done=1 in cycle WIDTH+1.
  - The next start is accepted from cycle WIDTH+2.
- Ignored inputs:
  - start in SHIFT or DONE has no effect.
  - Changes on a, b or mode after the start edge have no effect on the stream in progress.
- Idle outputs: aout and bout are 0 whenever bit_valid=0.
- Reset mid-operation: rst=0 returns the block to IDLE at once with all outputs at their reset values; the partial stream is discarded. After rst returns to 1, a new start transmits from bit index 0.
- bit_ready=1 while bit_valid=0 has no effect.

Test Plan:
1. rst=0 for 3 cycles with random inputs -> bit_valid, aout, bout, last, busy, done all 0; after release with start=0 for 5 cycles, outputs stay 0.
2. a=32'hF000_000F, b=32'h0000_0000, mode=0, start pulse, bit_ready=1 -> aout sequence 1,1,1,1, then 24 zeros, then 1,1,1,1, while bout=0 throughout; last=1 only in cycle 32; done=1 only in cycle 33; busy=1 in cycles 1-32.
3. a=32'h0000_0001, b=32'h8000_0000, mode=1 -> first pair aout=1/bout=0; final pair (last=1) aout=0/bout=1; exactly 32 transfers.
4. Backpressure: a=32'hAAAA_5555, mode=0; drop bit_ready for 3 cycles while the pair at index 5 is presented -> aout and last hold; the pair at index 5 transfers once; total transfers = 32; done arrives 3 cycles later than in scenario 2.
5. During SHIFT, pulse start again and change a to 32'hFFFF_FFFF -> stream still carries the originally latched operand; no restart; a single done pulse.
6. Assert rst=0 while the pair at index 10 is presented -> all outputs 0 in the same cycle; after rst=1 and a new start, the stream resends from bit index 0 with a full 32 transfers.

Source files
------------

// File: rtl/serial_operand_tx_if.sv
// Bit-pair stream between the operand transmitter and the serial comparator.
// master drives bit_valid/aout/bout/last, slave drives bit_ready.
interface serial_operand_tx_if;
    logic bit_valid;
    logic bit_ready;
    logic aout;
    logic bout;
    logic last;

    modport master (
        output bit_valid,
        output aout,
        output bout,
        output last,
        input  bit_ready
    );

    modport slave (
        input  bit_valid,
        input  aout,
        input  bout,
        input  last,
        output bit_ready
    );
endinterface

// File: rtl/serial_operand_tx.sv
// Serial operand transmitter: loads a/b on start, streams one bit pair per
// valid/ready transfer (MSB- or LSB-first), pulses done after the last pair.
// Ports: clk, rst (async active-low), start, mode, a, b, busy, done,
//        tx (master side of the bit-pair stream).
module serial_operand_tx #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    serial_operand_tx_if.master tx
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [CNT_W-1:0] cnt;
    logic             valid;
    logic             load;
    logic             fire;
    logic             is_last;

    // LSB-first is handled by loading bit-reversed operands, so the
    // output always comes from the top bit and the shift is always left.
    always_comb begin
        ra = '0;
        rb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ra[i] = a[WIDTH-1-i];
            rb[i] = b[WIDTH-1-i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt   = state;
        busy  = 1'b0;
        done  = 1'b0;
        valid = 1'b0;
        load  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    nxt  = SHIFT;
                end
            end
            SHIFT: begin
                busy  = 1'b1;
                valid = 1'b1;
                if (tx.bit_ready && is_last) nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign is_last = (state == SHIFT) && (cnt == CNT_W'(WIDTH-1));
    assign fire    = valid && tx.bit_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sa  <= '0;
            sb  <= '0;
            cnt <= '0;
        end else if (load) begin
            sa  <= mode ? ra : a;
            sb  <= mode ? rb : b;
            cnt <= '0;
        end else if (fire) begin
            sa  <= {sa[WIDTH-2:0], 1'b0};
            sb  <= {sb[WIDTH-2:0], 1'b0};
            cnt <= cnt + 1'b1;
        end
    end

    assign tx.bit_valid = valid;
    assign tx.aout      = valid & sa[WIDTH-1];
    assign tx.bout      = valid & sb[WIDTH-1];
    assign tx.last      = is_last;

endmodule
